// File: rtl/demux2_sched.sv
// Burst scheduler for the 2-bit, 8-lane demux: it arbitrates a destination lane and
// then streams up to BURST items to that lane through registered select/data/strobe.
module demux2_sched #(
  parameter int BURST = 4,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_data,
  output logic       in_ready,
  input  logic [7:0] lane_ready,
  input  logic       mode,
  input  logic [2:0] fixed_sel,
  output logic [2:0] sel,
  output logic [1:0] out_data,
  output logic [7:0] out_valid,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         ptr, ptr_nxt;
  logic [2:0]         cur, cur_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               gmode, gmode_nxt;
  logic [2:0]         sel_nxt;
  logic [1:0]         data_nxt;
  logic [7:0]         valid_nxt;
  logic               busy_nxt;

  logic               rr_found;
  logic [2:0]         rr_lane;
  logic [2:0]         idx;
  logic               elig_found;
  logic [2:0]         elig_lane;
  logic               xfer;
  logic               last;

  // Round-robin search: first ready lane at or after ptr, wrapping modulo 8.
  always_comb begin
    rr_found = 1'b0;
    rr_lane  = ptr;
    idx      = '0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!rr_found && lane_ready[idx]) begin
        rr_found = 1'b1;
        rr_lane  = idx;
      end
    end
  end

  assign elig_found = mode ? lane_ready[fixed_sel] : rr_found;
  assign elig_lane  = mode ? fixed_sel : rr_lane;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cur_nxt   = cur;
    cnt_nxt   = cnt;
    gmode_nxt = gmode;
    sel_nxt   = sel;
    data_nxt  = out_data;
    valid_nxt = '0;
    busy_nxt  = busy;
    in_ready  = 1'b0;
    xfer      = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && elig_found) begin
          state_nxt = GRANT;
          cur_nxt   = elig_lane;
          cnt_nxt   = '0;
          gmode_nxt = mode;
          busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        in_ready = lane_ready[cur];
        xfer     = in_valid && lane_ready[cur];
        last     = (cnt == CNT_W'(BURST - 1));
        if (xfer) begin
          data_nxt  = in_data;
          sel_nxt   = cur;
          valid_nxt = 8'b1 << cur;
          cnt_nxt   = cnt + CNT_W'(1);
        end
        // A stalled or drained cycle ends the grant just like a full burst does.
        if (!xfer || last) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          if (!gmode) begin
            ptr_nxt = cur + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      cnt       <= '0;
      gmode     <= 1'b0;
      sel       <= '0;
      out_data  <= '0;
      out_valid <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cur       <= cur_nxt;
      cnt       <= cnt_nxt;
      gmode     <= gmode_nxt;
      sel       <= sel_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_demux2_sched.sv
// Self-checking bench for demux2_sched: directed scenarios followed by random traffic,
// all compared every cycle against a transaction-level model of the scheduler.
module tb_demux2_sched;
  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic [7:0] lane_ready;
  logic       mode;
  logic [2:0] fixed_sel;
  logic [2:0] sel;
  logic [1:0] out_data;
  logic [7:0] out_valid;
  logic       busy;

  always #5 clk = ~clk;

  demux2_sched #(.BURST(BURST), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .lane_ready(lane_ready), .mode(mode),
    .fixed_sel(fixed_sel), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int lane_hits[8];

  // Reference model: a grant is either open on a lane or not; it closes once an
  // offered cycle is not accepted or BURST items have gone out.
  bit         m_granted;
  int         m_lane;
  int         m_items;
  int         m_ptr;
  bit         m_gmode;
  logic [2:0] e_sel;
  logic [1:0] e_data;
  logic [7:0] e_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] lr, input logic md, input logic [2:0] fs, input int p);
    if (md) return lr[fs] ? int'(fs) : -1;
    for (int k = 0; k < 8; k++) begin
      if (lr[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_granted = 0; m_lane = 0; m_items = 0; m_ptr = 0; m_gmode = 0;
    e_sel = '0; e_data = '0; e_valid = '0;
  endtask

  task automatic modelStep();
    int  l;
    bit  acc;
    if (rst) begin
      modelReset();
    end else if (!m_granted) begin
      e_valid = '0;
      l = pick(lane_ready, mode, fixed_sel, m_ptr);
      if (in_valid && l >= 0) begin
        m_granted = 1; m_lane = l; m_items = 0; m_gmode = mode;
      end
    end else begin
      acc = in_valid && lane_ready[m_lane];
      if (acc) begin
        e_data  = in_data;
        e_sel   = 3'(m_lane);
        e_valid = 8'(1 << m_lane);
        m_items++;
      end else begin
        e_valid = '0;
      end
      if (!acc || m_items == BURST) begin
        m_granted = 0;
        if (!m_gmode) m_ptr = (m_lane + 1) % 8;
      end
    end
  endtask

  task automatic checkOutput();
    chk("sel", 32'(sel), 32'(e_sel));
    chk("out_data", 32'(out_data), 32'(e_data));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("busy", 32'(busy), 32'(m_granted));
    chk("onehot", 32'($countones(out_valid) <= 1), 32'd1);
    for (int i = 0; i < 8; i++) lane_hits[i] += int'(out_valid[i]);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [1:0] d,
                               input logic [7:0] lr, input logic md, input logic [2:0] fs);
    rst = r; in_valid = v; in_data = d; lane_ready = lr; mode = md; fixed_sel = fs;
    #1;
    chk("in_ready", 32'(in_ready), m_granted ? 32'(lr[m_lane]) : 32'd0);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic clearHits();
    for (int i = 0; i < 8; i++) lane_hits[i] = 0;
  endtask

  function automatic int totalHits();
    int s = 0;
    for (int i = 0; i < 8; i++) s += lane_hits[i];
    return s;
  endfunction

  initial begin
    logic       r, v, md;
    logic [1:0] d;
    logic [7:0] lr;
    logic [2:0] fs;

    rst = 1; in_valid = 0; in_data = 0; lane_ready = 0; mode = 0; fixed_sel = 0;
    @(posedge clk);
    #1;
    modelReset();
    clearHits();

    $display("[TB] reset with traffic pending");
    repeat (2) begin
      applyStimulus(1, 1, 2'd3, 8'hFF, 0, 0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_valid", 32'(out_valid), 32'd0);
    end
    applyStimulus(0, 1, 2'd2, 8'hFF, 0, 0);
    applyStimulus(0, 1, 2'd1, 8'hFF, 0, 0);
    chk("first_grant_lane0", 32'(out_valid), 32'h01);

    $display("[TB] round-robin sweep");
    applyStimulus(1, 0, 0, 8'hFF, 0, 0);
    clearHits();
    for (int k = 0; k < 40; k++) applyStimulus(0, 1, 2'(k % 4), 8'hFF, 0, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rr_lane%0d_items", i), 32'(lane_hits[i]), 32'd4);

    $display("[TB] skip non-ready lanes");
    applyStimulus(1, 0, 0, 8'hA0, 0, 0);
    clearHits();
    for (int k = 0; k < 30; k++) applyStimulus(0, 1, 2'($urandom_range(0, 3)), 8'hA0, 0, 0);
    chk("skip_lane5_items", 32'(lane_hits[5]), 32'd12);
    chk("skip_lane7_items", 32'(lane_hits[7]), 32'd12);
    chk("skip_other_items", 32'(totalHits() - lane_hits[5] - lane_hits[7]), 32'd0);

    $display("[TB] mid-burst release");
    applyStimulus(1, 0, 0, 8'h0C, 0, 0);
    clearHits();
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 2'(k), 8'h0C, 0, 0);
    applyStimulus(0, 1, 2'd3, 8'h08, 0, 0);
    chk("midburst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 5; k++) applyStimulus(0, 1, 2'(k % 4), 8'h08, 0, 0);
    chk("midburst_lane2_items", 32'(lane_hits[2]), 32'd2);
    chk("midburst_lane3_items", 32'(lane_hits[3]), 32'd4);

    $display("[TB] fixed lane mode");
    applyStimulus(1, 0, 0, 8'hFF, 1, 3'd6);
    clearHits();
    for (int k = 0; k < 15; k++) applyStimulus(0, 1, 2'($urandom_range(0, 3)), 8'hFF, 1, 3'd6);
    chk("fixed_lane6_items", 32'(lane_hits[6]), 32'd12);
    chk("fixed_other_items", 32'(totalHits() - lane_hits[6]), 32'd0);
    clearHits();
    for (int k = 0; k < 10; k++) applyStimulus(0, 1, 2'($urandom_range(0, 3)), 8'hBF, 1, 3'd6);
    chk("fixed_blocked_items", 32'(totalHits()), 32'd0);

    $display("[TB] reset during grant");
    applyStimulus(1, 0, 0, 8'hFF, 0, 0);
    for (int k = 0; k < 5; k++) applyStimulus(0, 1, 2'(k % 4), 8'hFF, 0, 0);
    applyStimulus(0, 1, 2'd0, 8'hFF, 0, 0);
    applyStimulus(0, 1, 2'd1, 8'hFF, 0, 0);
    applyStimulus(1, 1, 2'd2, 8'hFF, 0, 0);
    chk("grant_reset_valid", 32'(out_valid), 32'd0);
    chk("grant_reset_busy", 32'(busy), 32'd0);
    applyStimulus(0, 1, 2'd3, 8'hFF, 0, 0);
    applyStimulus(0, 1, 2'd2, 8'hFF, 0, 0);
    chk("grant_reset_restart_lane0", 32'(out_valid), 32'h01);

    $display("[TB] random traffic");
    md = 0; fs = 0;
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 9) != 0);
      d  = 2'($urandom_range(0, 3));
      lr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'($urandom) | 8'($urandom));
      if ($urandom_range(0, 19) == 0) md = ~md;
      if ($urandom_range(0, 9) == 0) fs = 3'($urandom_range(0, 7));
      applyStimulus(r, v, d, lr, md, fs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
